// File: rtl/gfx_axi_pixel_writer.sv
// rtl/gfx_axi_pixel_writer.sv - pixel stream to single-beat AXI4 framebuffer writes
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   s_valid/s_ready     pixel stream handshake; s_x, s_y, s_color = {r,g,b}
//   m_axi_aw*           write address channel (single beat, INCR, id 0)
//   m_axi_w*            write data channel (all strobes set, wlast = 1)
//   m_axi_b*            write response channel (bready tied high)
//   idle                nothing pending on AW/W and no response outstanding
//   err                 sticky; set by any non-OKAY bresp
//   clip_cnt            saturating count of off-screen pixels dropped

module gfx_axi_pixel_writer #(
   parameter int H_WIDTH         = 12,
   parameter int V_WIDTH         = 12,
   parameter int COLOR_WIDTH     = 4,
   parameter int H_VISIBLE       = 640,
   parameter int V_VISIBLE       = 480,
   parameter int AXI_ADDR_WIDTH  = 20,
   parameter int AXI_DATA_WIDTH  = 16,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic                        s_valid,
   input  logic [H_WIDTH-1:0]          s_x,
   input  logic [V_WIDTH-1:0]          s_y,
   input  logic [3*COLOR_WIDTH-1:0]    s_color,
   output logic                        s_ready,

   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,

   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,

   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,

   output logic                        idle,
   output logic                        err,
   output logic [15:0]                 clip_cnt
);

   localparam int BYTES      = AXI_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(BYTES);
   // Linear index times bytes-per-pixel must never lose bits before the
   // final truncation to the AXI address width.
   localparam int RAW_W      = H_WIDTH + V_WIDTH + BYTE_SHIFT;
   localparam int CALC_W     = (RAW_W > AXI_ADDR_WIDTH) ? RAW_W : AXI_ADDR_WIDTH;
   localparam int OUT_W      = 4;

   localparam logic [H_WIDTH:0]   H_LIMIT = (H_WIDTH+1)'(H_VISIBLE);
   localparam logic [V_WIDTH:0]   V_LIMIT = (V_WIDTH+1)'(V_VISIBLE);
   localparam logic [OUT_W-1:0]   OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   logic                      awvalid_q;
   logic                      wvalid_q;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
   logic [AXI_DATA_WIDTH-1:0] wdata_q;
   logic [OUT_W-1:0]          outstanding_q;
   logic                      err_q;
   logic [15:0]               clip_cnt_q;

   logic                      in_range;
   logic                      accept;
   logic                      pix_write;
   logic                      pix_clip;
   logic                      b_hs;
   logic [CALC_W-1:0]         lin_index;
   logic [AXI_ADDR_WIDTH-1:0] byte_addr;
   logic                      unused_bid;

   assign m_axi_awid    = '0;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'(BYTE_SHIFT);
   assign m_axi_awburst = 2'b01;
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_bready  = 1'b1;

   // Responses are always single-ID, so the returned ID carries no information.
   assign unused_bid = ^m_axi_bid;

   assign in_range  = ({1'b0, s_x} < H_LIMIT) && ({1'b0, s_y} < V_LIMIT);

   // Gated by rst_n so the upstream stage sees no acceptance while in reset.
   assign s_ready   = rst_n && !awvalid_q && !wvalid_q && (outstanding_q < OUT_MAX);
   assign accept    = s_valid && s_ready;
   assign pix_write = accept && in_range;
   assign pix_clip  = accept && !in_range;

   // A response with nothing outstanding is a protocol violation; drop it so
   // the counter cannot wrap.
   assign b_hs = m_axi_bvalid && (outstanding_q != '0);

   // Constant multiply by the framebuffer width; synthesis reduces this to
   // shift-add.
   assign lin_index = CALC_W'(s_y) * CALC_W'(H_VISIBLE) + CALC_W'(s_x);
   assign byte_addr = AXI_ADDR_WIDTH'(lin_index << BYTE_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         clip_cnt_q    <= 16'd0;
      end else begin
         // AW and W retire independently; a new write can only load when both
         // are idle, so loading never collides with a pending handshake.
         if (pix_write) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= byte_addr;
         end else if (m_axi_awready) begin
            awvalid_q <= 1'b0;
         end

         if (pix_write) begin
            wvalid_q <= 1'b1;
            wdata_q  <= AXI_DATA_WIDTH'(s_color);
         end else if (m_axi_wready) begin
            wvalid_q <= 1'b0;
         end

         unique case ({pix_write, b_hs})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase

         if (b_hs && (m_axi_bresp != 2'b00)) begin
            err_q <= 1'b1;
         end

         if (pix_clip && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_q <= clip_cnt_q + 16'd1;
         end
      end
   end

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign err           = err_q;
   assign clip_cnt      = clip_cnt_q;
   assign idle          = (outstanding_q == '0) && !awvalid_q && !wvalid_q;

endmodule

// File: tb/tb_gfx_axi_pixel_writer.sv
// tb/tb_gfx_axi_pixel_writer.sv - directed and randomized checks for gfx_axi_pixel_writer

module tb_gfx_axi_pixel_writer;

   localparam int HV = 640;
   localparam int VV = 480;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [11:0] s_x = '0;
   logic [11:0] s_y = '0;
   logic [11:0] s_color = '0;
   logic        s_ready;
   logic        awvalid, awready = 1'b0;
   logic [19:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid, wready = 1'b0;
   logic [15:0] wdata;
   logic [1:0]  wstrb;
   logic        wlast;
   logic        bvalid = 1'b0, bready;
   logic [3:0]  bid = '0;
   logic [1:0]  bresp = '0;
   logic        idle, err;
   logic [15:0] clip_cnt;

   int n_checks = 0;
   int n_err    = 0;
   int model_out = 0;

   always #5 clk = ~clk;

   gfx_axi_pixel_writer dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_x(s_x), .s_y(s_y), .s_color(s_color), .s_ready(s_ready),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
      .m_axi_awid(awid), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
      .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp),
      .idle(idle), .err(err), .clip_cnt(clip_cnt)
   );

   // Framebuffer byte address of a pixel: row-major, 2 bytes per pixel, 20-bit bus.
   function automatic logic [31:0] exp_addr(input int x, input int y);
      return 32'(((y * HV + x) * 2) % (1 << 20));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one pixel at the current falling edge and drive AW/W ready after
   // the given number of valid cycles; returns what was first presented.
   task automatic write_pixel(input int x, input int y, input logic [11:0] c,
                              input int aw_dly, input int w_dly,
                              output logic [31:0] got_addr, output logic [31:0] got_data,
                              output int w_cycles);
      int cyc;
      check("ready_before_accept", 32'(s_ready), 32'(model_out < 4));
      s_valid = 1'b1; s_x = 12'(x); s_y = 12'(y); s_color = c;
      @(negedge clk);
      s_valid = 1'b0;
      check("valids_after_accept", 32'({awvalid, wvalid}), 32'h3);
      got_addr = 32'(awaddr);
      got_data = 32'(wdata);
      w_cycles = 0;
      cyc = 0;
      while ((awvalid || wvalid) && cyc < 40) begin
         if (awvalid) check("awaddr", 32'(awaddr), exp_addr(x, y));
         if (wvalid)  check("wdata", 32'(wdata), 32'(c));
         if (cyc > aw_dly) check("awvalid_dropped", 32'(awvalid), 32'h0);
         if (cyc > w_dly)  check("wvalid_dropped", 32'(wvalid), 32'h0);
         check("s_ready_while_busy", 32'(s_ready), 32'h0);
         if (wvalid) w_cycles++;
         awready = (cyc >= aw_dly);
         wready  = (cyc >= w_dly);
         @(negedge clk);
         cyc++;
      end
      check("write_done", 32'({awvalid, wvalid}), 32'h0);
      awready = 1'b0;
      wready  = 1'b0;
      model_out++;
   endtask

   task automatic send_b(input logic [1:0] r);
      bvalid = 1'b1; bresp = r;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
      model_out--;
   endtask

   initial begin
      logic [31:0] ga, gd, ea;
      logic [11:0] col;
      logic        bad;
      int          wc, x, y, accepted, aw_cnt;
      logic [31:0] q[$];

      // Reset state, sampled before any clock edge
      #3;
      check("rst_s_ready", 32'(s_ready), 32'h0);
      check("rst_valids", 32'({awvalid, wvalid}), 32'h0);
      check("rst_idle", 32'(idle), 32'h1);
      check("rst_err", 32'(err), 32'h0);
      check("rst_clip", 32'(clip_cnt), 32'h0);
      check("rst_awaddr", 32'(awaddr), 32'h0);
      check("rst_wdata", 32'(wdata), 32'h0);
      check("const_aw", 32'({awid, awlen, awsize, awburst}), 32'h00_0_01_1 >> 0 == 0 ? 0 : {4'h0, 8'h00, 3'd1, 2'b01});
      check("const_w_b", 32'({wstrb, wlast, bready}), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(s_ready), 32'h1);

      // Single pixel
      write_pixel(3, 2, 12'hF0A, 0, 0, ga, gd, wc);
      check("t1_awaddr", ga, 32'h0A06);
      check("t1_wdata", gd, 32'h0F0A);
      check("t1_not_idle", 32'(idle), 32'h0);
      @(negedge clk);
      send_b(2'b00);
      check("t1_idle", 32'(idle), 32'h1);
      check("t1_err", 32'(err), 32'h0);

      // Randomized in-range pixels with random AW/W stalls, plus corners
      for (int i = 0; i < 22; i++) begin
         if (i == 0)      begin x = HV - 1; y = VV - 1; end
         else if (i == 1) begin x = 0; y = 0; end
         else begin x = $urandom_range(0, HV - 1); y = $urandom_range(0, VV - 1); end
         col = 12'($urandom);
         write_pixel(x, y, col, $urandom_range(0, 3), $urandom_range(0, 3), ga, gd, wc);
         send_b(2'b00);
         check("rand_idle", 32'(idle), 32'h1);
      end

      // W held off for 5 cycles while AW completes at once
      col = 12'h5C3;
      write_pixel(100, 50, col, 0, 4, ga, gd, wc);
      check("wstall_w_cycles", 32'(wc), 32'd5);
      check("wstall_ready_after", 32'(s_ready), 32'h1);
      send_b(2'b00);

      // Clipping
      s_valid = 1'b1; s_x = 12'd640; s_y = 12'd0;
      check("clip_ready0", 32'(s_ready), 32'h1);
      @(negedge clk);
      s_x = 12'd0; s_y = 12'd480;
      check("clip_no_aw0", 32'({awvalid, wvalid}), 32'h0);
      check("clip_ready1", 32'(s_ready), 32'h1);
      @(negedge clk);
      s_valid = 1'b0;
      check("clip_no_aw1", 32'({awvalid, wvalid}), 32'h0);
      check("clip_cnt2", 32'(clip_cnt), 32'd2);
      bad = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 65600; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            s_x = 12'($urandom_range(HV, 4095)); s_y = 12'($urandom_range(0, 4095));
         end else begin
            s_x = 12'($urandom_range(0, 4095)); s_y = 12'($urandom_range(VV, 4095));
         end
         @(negedge clk);
         if (awvalid || wvalid || !s_ready || !idle) bad = 1'b1;
         if (i == 999) check("clip_cnt1002", 32'(clip_cnt), 32'd1002);
      end
      s_valid = 1'b0;
      check("clip_no_axi_activity", 32'(bad), 32'h0);
      check("clip_saturated", 32'(clip_cnt), 32'hFFFF);

      // Responses withheld, back-to-back pixels offered
      awready = 1'b1; wready = 1'b1;
      accepted = 0; aw_cnt = 0;
      s_valid = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (awvalid) begin
            aw_cnt++;
            check("full_awaddr", 32'(awaddr), q.pop_front());
         end
         if (s_ready && accepted < 10) begin
            x = $urandom_range(0, HV - 1); y = $urandom_range(0, VV - 1);
            s_x = 12'(x); s_y = 12'(y); s_color = 12'($urandom);
            q.push_back(exp_addr(x, y));
            accepted++;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      model_out += 4;
      check("full_aw_count", 32'(aw_cnt), 32'd4);
      check("full_accepted", 32'(accepted), 32'd4);
      check("full_ready", 32'(s_ready), 32'h0);
      check("full_q_empty", 32'(q.size()), 32'd0);

      send_b(2'b00);
      check("ready_after_b", 32'(s_ready), 32'h1);
      // Accept and response in the same cycle
      x = 17; y = 300;
      s_valid = 1'b1; s_x = 12'(x); s_y = 12'(y); s_color = 12'hABC;
      bvalid = 1'b1; bresp = 2'b00;
      @(negedge clk);
      s_valid = 1'b0; bvalid = 1'b0;
      check("acc_b_awvalid", 32'(awvalid), 32'h1);
      check("acc_b_awaddr", 32'(awaddr), exp_addr(x, y));
      @(negedge clk);
      check("acc_b_count_kept", 32'(s_ready), 32'h1);
      awready = 1'b0; wready = 1'b0;
      write_pixel(5, 6, 12'h123, 1, 0, ga, gd, wc);
      check("refull_ready", 32'(s_ready), 32'h0);
      check("refull_not_idle", 32'(idle), 32'h0);

      // Error response on the second of four
      send_b(2'b00);
      check("err_after_okay", 32'(err), 32'h0);
      send_b(2'b10);
      check("err_after_slverr", 32'(err), 32'h1);
      send_b(2'b00);
      check("err_sticky1", 32'(err), 32'h1);
      send_b(2'b00);
      check("err_sticky2", 32'(err), 32'h1);
      check("drained_idle", 32'(idle), 32'h1);

      // Stray response with nothing outstanding
      bvalid = 1'b1;
      @(negedge clk);
      bvalid = 1'b0;
      check("stray_b_ready", 32'(s_ready), 32'h1);
      check("stray_b_idle", 32'(idle), 32'h1);

      // Asynchronous reset mid-transaction
      write_pixel(1, 1, 12'h111, 0, 0, ga, gd, wc);
      write_pixel(2, 1, 12'h222, 0, 0, ga, gd, wc);
      s_valid = 1'b1; s_x = 12'd9; s_y = 12'd9; s_color = 12'h999;
      @(negedge clk);
      s_valid = 1'b0;
      check("pre_rst_awvalid", 32'(awvalid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valids", 32'({awvalid, wvalid}), 32'h0);
      check("arst_idle", 32'(idle), 32'h1);
      check("arst_ready", 32'(s_ready), 32'h0);
      check("arst_err", 32'(err), 32'h0);
      check("arst_clip", 32'(clip_cnt), 32'h0);
      check("arst_awaddr", 32'(awaddr), 32'h0);
      model_out = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_arst_ready", 32'(s_ready), 32'h1);
      check("post_arst_idle", 32'(idle), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
